// File: rtl/zeroheti_apb_timer_group_if.sv
// APB completer-side bus bundle for the zeroHETI timer group; the master drives
// the request, the slave answers in the same access phase (no wait states).
interface zeroheti_apb_timer_group_if #(
  parameter int unsigned AddrWidth = 12
);
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [AddrWidth-1:0] paddr;
  logic [31:0]          pwdata;
  logic [3:0]           pstrb;
  logic [31:0]          prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/zeroheti_apb_timer_group.sv
// NumTimers prescaled 32-bit APB timers, one interrupt line each; zero-wait-state APB.
// Define ZEROHETI_TG_IRQ_PULSE_EN for one-cycle irq pulses on pending rise instead of level irqs.
module zeroheti_apb_timer_group #(
  parameter int unsigned NumTimers = 2,
  parameter int unsigned AddrWidth = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  zeroheti_apb_timer_group_if.slave    apb,
  output logic [NumTimers-1:0]         irq_o
);

  localparam int unsigned TselW = AddrWidth - 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    merge = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merge[8*b +: 8] = wd[8*b +: 8];
    end
  endfunction

  // Register state
  state_e               state_q    [NumTimers];
  state_e               state_d    [NumTimers];
  logic [7:0]           prescale_q [NumTimers];
  logic [7:0]           prescale_d [NumTimers];
  logic [7:0]           pre_q      [NumTimers];
  logic [7:0]           pre_d      [NumTimers];
  logic [31:0]          count_q    [NumTimers];
  logic [31:0]          count_d    [NumTimers];
  logic [31:0]          cmp_q      [NumTimers];
  logic [31:0]          cmp_d      [NumTimers];
  logic [NumTimers-1:0] periodic_q, periodic_d;
  logic [NumTimers-1:0] irq_en_q, irq_en_d;
  logic [NumTimers-1:0] pending_q, pending_d;

  // Bus decode
  logic                 access;
  logic                 addr_err;
  logic                 wr_ok;
  logic [AddrWidth-1:0] addr;
  logic [TselW-1:0]     tsel;
  logic [1:0]           rsel;
  logic [31:0]          rdata;

  assign access   = apb.psel & apb.penable;
  assign addr     = apb.paddr;
  assign tsel     = addr[AddrWidth-1:4];
  assign rsel     = addr[3:2];
  assign addr_err = (addr[1:0] != 2'b00) || (32'(addr) >= 32'(16 * NumTimers));
  assign wr_ok    = access & apb.pwrite & ~addr_err;

  logic [NumTimers-1:0] ctrl_wr, count_wr, cmp_wr, stat_wr;
  logic [NumTimers-1:0] tick, match;
  logic [31:0]          ctrl_rd  [NumTimers];
  logic [31:0]          ctrl_new [NumTimers];

  for (genvar g = 0; g < NumTimers; g++) begin : g_dec
    logic hit;
    assign hit         = wr_ok && (tsel == TselW'(g));
    assign ctrl_wr[g]  = hit && (rsel == 2'd0);
    assign count_wr[g] = hit && (rsel == 2'd1);
    assign cmp_wr[g]   = hit && (rsel == 2'd2);
    assign stat_wr[g]  = hit && (rsel == 2'd3);
    assign ctrl_rd[g]  = {16'b0, prescale_q[g], 5'b0, irq_en_q[g], periodic_q[g],
                          state_q[g] == RUN};
    assign ctrl_new[g] = merge(ctrl_rd[g], apb.pwdata, apb.pstrb);
    assign tick[g]     = (state_q[g] == RUN) && (pre_q[g] == prescale_q[g]);
    // The compare always sees the pre-write COUNT, so a same-cycle write cannot hide a match.
    assign match[g]    = tick[g] && (count_q[g] == cmp_q[g]);
  end

  // Next-state logic for every timer
  always_comb begin
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    pending_d  = pending_q;
    for (int i = 0; i < NumTimers; i++) begin
      state_d[i]    = state_q[i];
      prescale_d[i] = prescale_q[i];
      pre_d[i]      = pre_q[i];
      count_d[i]    = count_q[i];
      cmp_d[i]      = cmp_q[i];

      if (ctrl_wr[i]) begin
        pre_d[i] = 8'd0;
      end else if (state_q[i] == RUN) begin
        pre_d[i] = tick[i] ? 8'd0 : pre_q[i] + 8'd1;
      end

      if (count_wr[i]) begin
        count_d[i] = merge(count_q[i], apb.pwdata, apb.pstrb);
      end else if (tick[i]) begin
        if (match[i]) count_d[i] = periodic_q[i] ? 32'd0 : count_q[i];
        else          count_d[i] = count_q[i] + 32'd1;
      end

      if (cmp_wr[i]) cmp_d[i] = merge(cmp_q[i], apb.pwdata, apb.pstrb);

      if (ctrl_wr[i]) begin
        periodic_d[i] = ctrl_new[i][1];
        irq_en_d[i]   = ctrl_new[i][2];
        prescale_d[i] = ctrl_new[i][15:8];
      end
      // A software write to the enable byte wins over a one-shot auto-stop.
      if (ctrl_wr[i] && apb.pstrb[0]) begin
        state_d[i] = ctrl_new[i][0] ? RUN : IDLE;
      end else if (match[i] && !periodic_q[i]) begin
        state_d[i] = IDLE;
      end

      if (match[i]) begin
        pending_d[i] = 1'b1;
      end else if (stat_wr[i] && apb.pstrb[0] && apb.pwdata[0]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      periodic_q <= '0;
      irq_en_q   <= '0;
      pending_q  <= '0;
      for (int i = 0; i < NumTimers; i++) begin
        state_q[i]    <= IDLE;
        prescale_q[i] <= 8'd0;
        pre_q[i]      <= 8'd0;
        count_q[i]    <= 32'd0;
        cmp_q[i]      <= 32'd0;
      end
    end else begin
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      pending_q  <= pending_d;
      for (int i = 0; i < NumTimers; i++) begin
        state_q[i]    <= state_d[i];
        prescale_q[i] <= prescale_d[i];
        pre_q[i]      <= pre_d[i];
        count_q[i]    <= count_d[i];
        cmp_q[i]      <= cmp_d[i];
      end
    end
  end

  // Read mux
  always_comb begin
    rdata = 32'd0;
    for (int i = 0; i < NumTimers; i++) begin
      if (tsel == TselW'(i)) begin
        case (rsel)
          2'd0:    rdata = ctrl_rd[i];
          2'd1:    rdata = count_q[i];
          2'd2:    rdata = cmp_q[i];
          default: rdata = {31'b0, pending_q[i]};
        endcase
      end
    end
  end

  assign apb.pready  = access;
  assign apb.pslverr = access & addr_err;
  assign apb.prdata  = (access && !addr_err) ? rdata : 32'd0;

`ifdef ZEROHETI_TG_IRQ_PULSE_EN
  logic [NumTimers-1:0] pending_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pending_prev_q <= '0;
    else       pending_prev_q <= pending_q;
  end

  assign irq_o = pending_q & ~pending_prev_q & irq_en_q;
`else
  assign irq_o = pending_q & irq_en_q;
`endif

endmodule
